// File: rtl/sram_regfile_2r1w.sv
// sram_regfile_2r1w
//
// DEPTH x WIDTH storage array with one write port and two registered read ports.
// Serves as the CPU register file and as scratch RAM. After reset, or on a clr
// pulse while idle, a hardware sweep zeroes every word, one word per cycle. While
// the sweep runs, busy is high and all accesses (we/re1/re2) are ignored.
//
// Parameters:
//   WIDTH   data bits per word
//   DEPTH   number of words, 2 <= DEPTH <= 2**ADDR_W
//   ADDR_W  address bits per port
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             asynchronous active-high reset
//   clr             restart the clear sweep (only honoured while idle)
//   we/waddr/wdata  write port; addresses >= DEPTH are dropped
//   re1/raddr1      read port 1 request
//   re2/raddr2      read port 2 request
//   rdata1/rdata2   registered read data, one cycle after the request;
//                   held when not reading, 0 for addresses >= DEPTH
//   busy            high while the clear sweep runs
//
// Build option:
//   SRAM_BYPASS_EN  when defined, a read that hits the word being written in the
//                   same cycle returns the new write data. When undefined, the
//                   read returns the old contents (read-before-write).

module sram_regfile_2r1w #(
    parameter int unsigned WIDTH  = 15,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2,
    output logic              busy
);

    // One extra bit so that DEPTH == 2**ADDR_W is representable as a limit.
    localparam logic [ADDR_W:0]   DepthLim = DEPTH[ADDR_W:0];
    localparam int unsigned       LastIdx  = DEPTH - 1;
    localparam logic [ADDR_W-1:0] LastPtr  = LastIdx[ADDR_W-1:0];

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              idle;
    logic              waddr_ok;
    logic              raddr1_ok;
    logic              raddr2_ok;
    logic              wr_en;
    logic [WIDTH-1:0]  rd1_d;
    logic [WIDTH-1:0]  rd2_d;

    assign idle      = (state_q == StIdle);
    assign waddr_ok  = ({1'b0, waddr}  < DepthLim);
    assign raddr1_ok = ({1'b0, raddr1} < DepthLim);
    assign raddr2_ok = ({1'b0, raddr2} < DepthLim);
    assign wr_en     = idle & we & waddr_ok;
    assign busy      = busy_q;

    // Sweep controller. busy is registered alongside the state so it changes
    // exactly on the edges where the state does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StClear: begin
                    if (ptr_q == LastPtr) begin
                        state_q <= StIdle;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q   <= ptr_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (clr) begin
                        state_q <= StClear;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StClear;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep is what brings it to zero. A write issued
    // in the same cycle as clr still lands and is later zeroed by the sweep.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[ptr_q] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data selection for both ports.
    always_comb begin
        rd1_d = '0;
        if (raddr1_ok) begin
            rd1_d = mem[raddr1];
`ifdef SRAM_BYPASS_EN
            if (wr_en && (waddr == raddr1)) begin
                rd1_d = wdata;
            end
`endif
        end
    end

    always_comb begin
        rd2_d = '0;
        if (raddr2_ok) begin
            rd2_d = mem[raddr2];
`ifdef SRAM_BYPASS_EN
            if (wr_en && (waddr == raddr2)) begin
                rd2_d = wdata;
            end
`endif
        end
    end

    // Read registers update only on an enabled read while idle; otherwise they
    // hold, including through the whole sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (idle && re1) begin
                rdata1 <= rd1_d;
            end
            if (idle && re2) begin
                rdata2 <= rd2_d;
            end
        end
    end

endmodule

// File: tb/tb_sram_regfile_2r1w.sv
// Testbench for sram_regfile_2r1w. Two instances share one set of inputs:
// dut_a with DEPTH=16 and dut_b with DEPTH=12, so that every write to words
// 12..15 is also an out-of-range write for dut_b. A behavioural model (plain
// arrays plus a remaining-sweep-cycles counter per instance) predicts all
// outputs, and every falling edge compares them.

module tb_sram_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        we;
    logic [3:0]  waddr;
    logic [14:0] wdata;
    logic        re1;
    logic [3:0]  raddr1;
    logic        re2;
    logic [3:0]  raddr2;
    logic [14:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, busy_b;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state: index 0 models dut_a, index 1 models dut_b.
    int          mdepth [2] = '{16, 12};
    int          mbusy  [2];
    logic [14:0] mmem   [2][16];
    logic [14:0] mrd1   [2];
    logic [14:0] mrd2   [2];

    always #5 clk = ~clk;

    sram_regfile_2r1w #(.WIDTH(15), .DEPTH(16), .ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rd1_a), .rdata2(rd2_a), .busy(busy_a)
    );

    sram_regfile_2r1w #(.WIDTH(15), .DEPTH(12), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rd1_b), .rdata2(rd2_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mbusy[k] = mdepth[k];
            mrd1[k]  = '0;
            mrd2[k]  = '0;
            for (int i = 0; i < 16; i++) mmem[k][i] = '0;
        end
    endtask

    // What a read of address ra returns this cycle in instance k.
    function automatic logic [14:0] model_read(int k, logic [3:0] ra);
        if (int'(ra) >= mdepth[k]) return '0;
`ifdef SRAM_BYPASS_EN
        if (we && waddr == ra) return wdata;
`endif
        return mmem[k][ra];
    endfunction

    // One rising edge: a sweep just counts down (its result, all zeros, is applied
    // when it starts); idle cycles read old contents, then write, then maybe clear.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (mbusy[k] > 0) begin
                mbusy[k]--;
            end else begin
                if (re1) mrd1[k] = model_read(k, raddr1);
                if (re2) mrd2[k] = model_read(k, raddr2);
                if (we && int'(waddr) < mdepth[k]) mmem[k][waddr] = wdata;
                if (clr) begin
                    mbusy[k] = mdepth[k];
                    for (int i = 0; i < 16; i++) mmem[k][i] = '0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("busy_a",  32'(busy_a), 32'(mbusy[0] > 0));
        chk("busy_b",  32'(busy_b), 32'(mbusy[1] > 0));
        chk("rdata1_a", 32'(rd1_a), 32'(mrd1[0]));
        chk("rdata2_a", 32'(rd2_a), 32'(mrd2[0]));
        chk("rdata1_b", 32'(rd1_b), 32'(mrd1[1]));
        chk("rdata2_b", 32'(rd2_b), 32'(mrd2[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet();
        clr = 0; we = 0; waddr = '0; wdata = '0;
        re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [14:0] d);
        quiet(); we = 1; waddr = a; wdata = d;
        tick();
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2);
        quiet(); re1 = 1; raddr1 = a1; re2 = 1; raddr2 = a2;
        tick();
    endtask

    // Counts rising edges until dut_a drops busy, bounded.
    task automatic busy_len(output int n);
        n = 0;
        while (busy_a && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int          n;
        logic [14:0] held1, held2;

        // Reset and first sweep.
        quiet();
        rst = 1;
        model_reset();
        @(negedge clk);
        check_all();
        chk("reset_busy", 32'(busy_a), 32'd1);
        chk("reset_rdata1", 32'(rd1_a), 32'd0);
        tick();
        rst = 0;
        busy_len(n);
        chk("sweep_len_after_reset", n, 16);

        // Every word reads zero after the sweep.
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(15 - i));
            chk("cleared_word", 32'(rd1_a), 32'd0);
        end

        // Basic write then read on both ports.
        wr(4'd3, 15'h1234);
        wr(4'd15, 15'h7FFF);
        rd(4'd3, 4'd15);
        chk("read_p1_addr3", 32'(rd1_a), 32'h1234);
        chk("read_p2_addr15", 32'(rd2_a), 32'h7FFF);
        chk("read_p2_addr15_depth12", 32'(rd2_b), 32'h0);

        // Same-cycle write and read of one word.
        wr(4'd5, 15'h0AAA);
        quiet(); we = 1; waddr = 4'd5; wdata = 15'h0555; re1 = 1; raddr1 = 4'd5;
        tick();
`ifdef SRAM_BYPASS_EN
        chk("collide_bypass", 32'(rd1_a), 32'h0555);
`else
        chk("collide_old_data", 32'(rd1_a), 32'h0AAA);
`endif
        rd(4'd5, 4'd5);
        chk("after_collide_p1", 32'(rd1_a), 32'h0555);
        chk("after_collide_p2", 32'(rd2_a), 32'h0555);

        // Out-of-range addresses on the DEPTH=12 instance.
        wr(4'd11, 15'h2222);
        wr(4'd13, 15'h1111);
        rd(4'd13, 4'd11);
        chk("oob_read_depth12", 32'(rd1_b), 32'h0);
        chk("word11_depth12", 32'(rd2_b), 32'h2222);
        chk("word13_depth16", 32'(rd1_a), 32'h1111);

        // Read enable low holds the previous value.
        quiet(); raddr1 = 4'd3; raddr2 = 4'd3;
        tick();
        chk("hold_p1", 32'(rd1_a), 32'h1111);

        // Randomised traffic, with occasional clr pulses.
        for (int c = 0; c < 400; c++) begin
            quiet();
            we     = 1'($urandom_range(0, 1));
            waddr  = 4'($urandom_range(0, 15));
            wdata  = 15'($urandom);
            re1    = 1'($urandom_range(0, 1));
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            re2    = 1'($urandom_range(0, 1));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 4'($urandom_range(0, 15));
            clr    = ($urandom_range(0, 39) == 0);
            tick();
        end
        quiet();
        while (busy_a) tick();

        // clr with data loaded; reads during the sweep must not update rdata.
        wr(4'd7, 15'h3C3C);
        rd(4'd7, 4'd7);
        chk("preclr_read", 32'(rd1_a), 32'h3C3C);
        held1 = rd1_a;
        held2 = rd2_a;
        quiet(); clr = 1;
        tick();
        quiet(); re1 = 1; raddr1 = 4'd3; re2 = 1; raddr2 = 4'd0;
        busy_len(n);
        chk("sweep_len_after_clr", n, 16);
        chk("held_through_sweep_p1", 32'(rd1_a), 32'(held1));
        chk("held_through_sweep_p2", 32'(rd2_a), 32'(held2));
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 4'(i));
            chk("cleared_after_clr", 32'(rd2_a), 32'd0);
        end

        // clr while busy is ignored: sweep length unchanged.
        quiet(); clr = 1;
        tick();
        tick();
        n = 1;
        while (busy_a && n < 100) begin
            tick();
            n++;
        end
        chk("clr_while_busy_ignored", n, 16);

        // Reset asserted five cycles into a sweep.
        wr(4'd2, 15'h0F0F);
        rd(4'd2, 4'd2);
        quiet(); clr = 1;
        tick();
        quiet();
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("midsweep_rst_busy", 32'(busy_a), 32'd1);
        chk("midsweep_rst_rdata1", 32'(rd1_a), 32'd0);
        chk("midsweep_rst_rdata2", 32'(rd2_a), 32'd0);
        check_all();
        tick();
        tick();
        rst = 0;
        busy_len(n);
        chk("sweep_len_after_midsweep_rst", n, 16);
        rd(4'd2, 4'd7);
        chk("cleared_after_midsweep_rst", 32'(rd1_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
